// File: rtl/hazard_stall_controller.sv
// Load-use interlock and multi-cycle multiply/divide sequencer for the 5-stage pipeline.
// Define HAZARD_STALL_STATS_EN to add saturating stall_cycles / md_ops statistics counters.
module hazard_stall_controller #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic [31:0] xm_ir,
    input  logic        multdiv_rdy,
    input  logic        multdiv_exc,
    output logic        stall_fd,
    output logic        freeze_dx,
    output logic        bubble_dx,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        md_wren,
    output logic [4:0]  md_dest,
    output logic        md_error,
    output logic        md_busy
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] md_ops
`endif
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [4:0] ERR_REG  = 5'd30;
    localparam logic [7:0] TMO_LAST = 8'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       stall_md;
    logic       bubble_md;

    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_alu;
    logic       dx_mul, dx_div, dx_lw;
    logic       rd_rs, rd_rt, rd_rd, fd_dep, load_use;
    logic       done_hit, done_err;
    logic [4:0] done_dest;
    logic       unused_bits;

    assign fd_op  = fd_ir[31:27];
    assign fd_rd  = fd_ir[26:22];
    assign fd_rs  = fd_ir[21:17];
    assign fd_rt  = fd_ir[16:12];
    assign dx_op  = dx_ir[31:27];
    assign dx_rd  = dx_ir[26:22];
    assign dx_alu = dx_ir[6:2];

    // xm_ir is reserved for a later load-use extension
    assign unused_bits = ^{xm_ir, fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

    assign dx_mul = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
    assign dx_div = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);
    assign dx_lw  = (dx_op == OP_LW);

    assign rd_rs  = fd_op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_JR, OP_BNE, OP_BLT};
    assign rd_rt  = (fd_op == OP_RTYPE);
    assign rd_rd  = fd_op inside {OP_SW, OP_BNE, OP_BLT, OP_JR};
    assign fd_dep = (rd_rs && (fd_rs == dx_rd)) ||
                    (rd_rt && (fd_rt == dx_rd)) ||
                    (rd_rd && (fd_rd == dx_rd));

    // Gated by reset so every output reads 0 while reset is held, and by IDLE so multdiv wins
    assign load_use = reset && (state == IDLE) && dx_lw && (dx_rd != 5'd0) && fd_dep;

    assign stall_fd  = stall_md | load_use;
    assign bubble_dx = bubble_md | load_use;

    // A ready pulse on the timeout cycle still reports the unit's own exception status
    assign done_hit  = multdiv_rdy || (cnt == TMO_LAST);
    assign done_err  = multdiv_rdy ? multdiv_exc : 1'b1;
    assign done_dest = done_err ? ERR_REG : md_dest;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            md_dest   <= 5'd0;
            stall_md  <= 1'b0;
            bubble_md <= 1'b0;
            freeze_dx <= 1'b0;
            ctrl_mult <= 1'b0;
            ctrl_div  <= 1'b0;
            md_wren   <= 1'b0;
            md_error  <= 1'b0;
            md_busy   <= 1'b0;
        end else begin
            ctrl_mult <= 1'b0;
            ctrl_div  <= 1'b0;
            bubble_md <= 1'b0;
            md_wren   <= 1'b0;
            md_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (dx_mul || dx_div) begin
                        state     <= START;
                        md_dest   <= dx_rd;
                        ctrl_mult <= dx_mul;
                        ctrl_div  <= dx_div;
                        stall_md  <= 1'b1;
                        freeze_dx <= 1'b1;
                        md_busy   <= 1'b1;
                    end
                end
                START: begin
                    state <= BUSY;
                    cnt   <= 8'd0;
                end
                BUSY: begin
                    cnt <= cnt + 8'd1;
                    if (done_hit) begin
                        state     <= DONE;
                        freeze_dx <= 1'b0;
                        bubble_md <= 1'b1;
                        md_error  <= done_err;
                        md_dest   <= done_dest;
                        md_wren   <= (done_dest != 5'd0);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    stall_md <= 1'b0;
                    md_busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            md_ops       <= '0;
        end else begin
            if (stall_fd)
                stall_cycles <= sat_inc(stall_cycles);
            if (state == DONE)
                md_ops <= sat_inc(md_ops);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: per-cycle expected output vectors
// are queued as stimulus is driven and compared when the outputs are sampled.
module tb_hazard_stall_controller;

    localparam logic [31:0] ADD_7_5_2 = {5'b00000, 5'd7, 5'd5, 5'd2, 5'd0, 5'b00000, 2'b00};
    localparam logic [31:0] ADD_7_0_2 = {5'b00000, 5'd7, 5'd0, 5'd2, 5'd0, 5'b00000, 2'b00};
    localparam logic [31:0] ADD_7_2_5 = {5'b00000, 5'd7, 5'd2, 5'd5, 5'd0, 5'b00000, 2'b00};
    localparam logic [31:0] ADD_1_2_3 = {5'b00000, 5'd1, 5'd2, 5'd3, 5'd0, 5'b00000, 2'b00};
    localparam logic [31:0] MUL_9     = {5'b00000, 5'd9, 5'd3, 5'd4, 5'd0, 5'b00110, 2'b00};
    localparam logic [31:0] MUL_0     = {5'b00000, 5'd0, 5'd1, 5'd2, 5'd0, 5'b00110, 2'b00};
    localparam logic [31:0] DIV_4     = {5'b00000, 5'd4, 5'd1, 5'd2, 5'd0, 5'b00111, 2'b00};
    localparam logic [31:0] DIV_0     = {5'b00000, 5'd0, 5'd1, 5'd2, 5'd0, 5'b00111, 2'b00};
    localparam logic [31:0] LW_5      = {5'b01000, 5'd5, 5'd1, 17'd4};
    localparam logic [31:0] LW_0      = {5'b01000, 5'd0, 5'd1, 17'd4};
    localparam logic [31:0] SW_5      = {5'b00111, 5'd5, 5'd9, 17'd0};
    localparam logic [31:0] ADDI_5_9  = {5'b00101, 5'd5, 5'd9, 17'd1};
    localparam logic [31:0] J_5       = {5'b00001, 5'd5, 5'd5, 17'd0};
    localparam logic [31:0] BNE_5     = {5'b00010, 5'd5, 5'd1, 17'd8};

    typedef struct {
        logic [31:0] fd;
        logic [31:0] dx;
        logic        rdy;
        logic        exc;
        logic [12:0] ex;
    } cyc_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_ir = '0, dx_ir = '0, xm_ir = '0;
    logic        multdiv_rdy = 1'b0, multdiv_exc = 1'b0;

    logic       m_stall, m_freeze, m_bubble, m_cm, m_cd, m_wren, m_err, m_busy;
    logic [4:0] m_dest;
    logic       t_stall, t_freeze, t_bubble, t_cm, t_cd, t_wren, t_err, t_busy;
    logic [4:0] t_dest;
`ifdef HAZARD_STALL_STATS_EN
    logic [15:0] m_stall_cycles, m_md_ops;
    logic [2:0]  t_stall_cycles, t_md_ops;
`endif

    logic [12:0] got_m, got_t;
    logic [12:0] sb[$];
    int vectors = 0;
    int miscompares = 0;

    assign got_m = {m_stall, m_freeze, m_bubble, m_cm, m_cd, m_wren, m_dest, m_err, m_busy};
    assign got_t = {t_stall, t_freeze, t_bubble, t_cm, t_cd, t_wren, t_dest, t_err, t_busy};

    hazard_stall_controller dut (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir), .xm_ir(xm_ir),
        .multdiv_rdy(multdiv_rdy), .multdiv_exc(multdiv_exc),
        .stall_fd(m_stall), .freeze_dx(m_freeze), .bubble_dx(m_bubble),
        .ctrl_mult(m_cm), .ctrl_div(m_cd), .md_wren(m_wren), .md_dest(m_dest),
        .md_error(m_err), .md_busy(m_busy)
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cycles(m_stall_cycles), .md_ops(m_md_ops)
`endif
    );

    hazard_stall_controller #(.MD_TIMEOUT(4), .CNT_W(3)) dut_t (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir), .xm_ir(xm_ir),
        .multdiv_rdy(multdiv_rdy), .multdiv_exc(multdiv_exc),
        .stall_fd(t_stall), .freeze_dx(t_freeze), .bubble_dx(t_bubble),
        .ctrl_mult(t_cm), .ctrl_div(t_cd), .md_wren(t_wren), .md_dest(t_dest),
        .md_error(t_err), .md_busy(t_busy)
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cycles(t_stall_cycles), .md_ops(t_md_ops)
`endif
    );

    always #5 clock = ~clock;

    // Order: stall, freeze, bubble, ctrl_mult, ctrl_div, wren, dest, error, busy
    function automatic logic [12:0] mk(input logic s, f, b, cm, cd, w, input logic [4:0] d,
                                       input logic e, bz);
        return {s, f, b, cm, cd, w, d, e, bz};
    endfunction

    function automatic cyc_t cy(input logic [31:0] fd, dx, input logic rdy, exc,
                                input logic [12:0] ex);
        cyc_t c;
        c.fd = fd; c.dx = dx; c.rdy = rdy; c.exc = exc; c.ex = ex;
        return c;
    endfunction

    task automatic drive_cycle(input cyc_t c);
        @(posedge clock);
        #1;
        fd_ir = c.fd;
        dx_ir = c.dx;
        multdiv_rdy = c.rdy;
        multdiv_exc = c.exc;
        sb.push_back(c.ex);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        fd_ir = '0; dx_ir = '0; multdiv_rdy = 1'b0; multdiv_exc = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] ex;
        #2;
        reset = 1'b0;
        fd_ir = ADD_7_5_2;
        dx_ir = LW_5;
        sb.push_back(13'd0);
        @(negedge clock);
        ex = sb.pop_front(); vectors++;
        if (got_m !== ex) begin
            miscompares++;
            $display("FAIL reset_loaduse: got %b expected %b", got_m, ex);
        end
        dx_ir = MUL_9;
        sb.push_back(13'd0);
        @(posedge clock);
        @(negedge clock);
        ex = sb.pop_front(); vectors++;
        if (got_m !== ex) begin
            miscompares++;
            $display("FAIL reset_multdiv: got %b expected %b", got_m, ex);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        dx_ir = '0;
        fd_ir = '0;
        sb.push_back(13'd0);
        @(negedge clock);
        ex = sb.pop_front(); vectors++;
        if (got_m !== ex) begin
            miscompares++;
            $display("FAIL reset_release: got %b expected %b", got_m, ex);
        end
    endtask

    task automatic test_load_use();
        cyc_t tbl[$];
        logic [12:0] ex, lu, z;
        lu = mk(1, 0, 1, 0, 0, 0, 5'd0, 0, 0);
        z  = mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0);
        do_reset();
        tbl.push_back(cy(ADD_7_5_2, LW_5, 0, 0, lu));
        tbl.push_back(cy(ADD_7_5_2, 32'd0, 0, 0, z));
        tbl.push_back(cy(ADD_7_0_2, LW_0, 0, 0, z));
        tbl.push_back(cy(SW_5, LW_5, 0, 0, lu));
        tbl.push_back(cy(ADDI_5_9, LW_5, 0, 0, z));
        tbl.push_back(cy(ADD_7_2_5, LW_5, 0, 0, lu));
        tbl.push_back(cy(J_5, LW_5, 0, 0, z));
        tbl.push_back(cy(BNE_5, LW_5, 0, 0, lu));
        tbl.push_back(cy(ADD_7_5_2, 32'd0, 0, 0, z));
        foreach (tbl[i]) begin
            drive_cycle(tbl[i]);
            @(negedge clock);
            ex = sb.pop_front(); vectors++;
            if (got_m !== ex) begin
                miscompares++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, got_m, ex);
            end
        end
    endtask

    task automatic test_multiply();
        cyc_t tbl[$];
        logic [12:0] ex;
        do_reset();
        tbl.push_back(cy(ADD_1_2_3, MUL_9, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0)));
        tbl.push_back(cy(ADD_1_2_3, MUL_9, 0, 0, mk(1, 1, 0, 1, 0, 0, 5'd9, 0, 1)));
        for (int k = 0; k < 5; k++)
            tbl.push_back(cy(ADD_1_2_3, MUL_9, 0, 0, mk(1, 1, 0, 0, 0, 0, 5'd9, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, MUL_9, 1, 0, mk(1, 1, 0, 0, 0, 0, 5'd9, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, MUL_9, 0, 0, mk(1, 0, 1, 0, 0, 1, 5'd9, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, 32'd0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd9, 0, 0)));
        foreach (tbl[i]) begin
            drive_cycle(tbl[i]);
            @(negedge clock);
            ex = sb.pop_front(); vectors++;
            if (got_m !== ex) begin
                miscompares++;
                $display("FAIL multiply[%0d]: got %b expected %b", i, got_m, ex);
            end
        end
    endtask

    task automatic test_div_exception();
        cyc_t tbl[$];
        logic [12:0] ex;
        do_reset();
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0)));
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(1, 1, 0, 0, 1, 0, 5'd4, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 1, 1, mk(1, 1, 0, 0, 0, 0, 5'd4, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(1, 0, 1, 0, 0, 1, 5'd30, 1, 1)));
        tbl.push_back(cy(ADD_1_2_3, 32'd0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd30, 0, 0)));
        // r0 destination: write discarded without error, but still reported with error
        tbl.push_back(cy(ADD_1_2_3, MUL_0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd30, 0, 0)));
        tbl.push_back(cy(ADD_1_2_3, MUL_0, 0, 0, mk(1, 1, 0, 1, 0, 0, 5'd0, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, MUL_0, 1, 0, mk(1, 1, 0, 0, 0, 0, 5'd0, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, MUL_0, 0, 0, mk(1, 0, 1, 0, 0, 0, 5'd0, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, 32'd0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0)));
        tbl.push_back(cy(ADD_1_2_3, DIV_0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0)));
        tbl.push_back(cy(ADD_1_2_3, DIV_0, 0, 0, mk(1, 1, 0, 0, 1, 0, 5'd0, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, DIV_0, 1, 1, mk(1, 1, 0, 0, 0, 0, 5'd0, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, DIV_0, 0, 0, mk(1, 0, 1, 0, 0, 1, 5'd30, 1, 1)));
        tbl.push_back(cy(ADD_1_2_3, 32'd0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd30, 0, 0)));
        foreach (tbl[i]) begin
            drive_cycle(tbl[i]);
            @(negedge clock);
            ex = sb.pop_front(); vectors++;
            if (got_m !== ex) begin
                miscompares++;
                $display("FAIL div_exception[%0d]: got %b expected %b", i, got_m, ex);
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc_t tbl[$];
        logic [12:0] ex;
        do_reset();
        tbl.push_back(cy(DIV_4, MUL_9, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0)));
        tbl.push_back(cy(DIV_4, MUL_9, 0, 0, mk(1, 1, 0, 1, 0, 0, 5'd9, 0, 1)));
        tbl.push_back(cy(DIV_4, MUL_9, 1, 0, mk(1, 1, 0, 0, 0, 0, 5'd9, 0, 1)));
        tbl.push_back(cy(DIV_4, MUL_9, 0, 0, mk(1, 0, 1, 0, 0, 1, 5'd9, 0, 1)));
        tbl.push_back(cy(DIV_4, 32'd0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd9, 0, 0)));
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd9, 0, 0)));
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(1, 1, 0, 0, 1, 0, 5'd4, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 1, 0, mk(1, 1, 0, 0, 0, 0, 5'd4, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(1, 0, 1, 0, 0, 1, 5'd4, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, 32'd0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd4, 0, 0)));
        foreach (tbl[i]) begin
            drive_cycle(tbl[i]);
            @(negedge clock);
            ex = sb.pop_front(); vectors++;
            if (got_m !== ex) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %b expected %b", i, got_m, ex);
            end
        end
    endtask

    task automatic test_timeout();
        cyc_t tbl[$];
        logic [12:0] ex;
        do_reset();
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0)));
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(1, 1, 0, 0, 1, 0, 5'd4, 0, 1)));
        for (int k = 0; k < 4; k++)
            tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(1, 1, 0, 0, 0, 0, 5'd4, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(1, 0, 1, 0, 0, 1, 5'd30, 1, 1)));
        tbl.push_back(cy(ADD_1_2_3, 32'd0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd30, 0, 0)));
        // Ready arriving on the timeout cycle takes precedence
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd30, 0, 0)));
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(1, 1, 0, 0, 1, 0, 5'd4, 0, 1)));
        for (int k = 0; k < 3; k++)
            tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(1, 1, 0, 0, 0, 0, 5'd4, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 1, 0, mk(1, 1, 0, 0, 0, 0, 5'd4, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, DIV_4, 0, 0, mk(1, 0, 1, 0, 0, 1, 5'd4, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, 32'd0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd4, 0, 0)));
        foreach (tbl[i]) begin
            drive_cycle(tbl[i]);
            @(negedge clock);
            ex = sb.pop_front(); vectors++;
            if (got_t !== ex) begin
                miscompares++;
                $display("FAIL timeout[%0d]: got %b expected %b", i, got_t, ex);
            end
        end
`ifdef HAZARD_STALL_STATS_EN
        vectors++;
        if (t_stall_cycles !== 3'd7) begin
            miscompares++;
            $display("FAIL stall_cycles_saturate: got %0d expected 7", t_stall_cycles);
        end
        vectors++;
        if (t_md_ops !== 3'd2) begin
            miscompares++;
            $display("FAIL md_ops_count: got %0d expected 2", t_md_ops);
        end
`endif
    endtask

    task automatic test_priority();
        cyc_t tbl[$];
        logic [12:0] ex;
        do_reset();
        tbl.push_back(cy(ADD_7_5_2, MUL_9, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0)));
        tbl.push_back(cy(ADD_7_5_2, LW_5, 0, 0, mk(1, 1, 0, 1, 0, 0, 5'd9, 0, 1)));
        for (int k = 0; k < 5; k++)
            tbl.push_back(cy(ADD_7_5_2, LW_5, 0, 0, mk(1, 1, 0, 0, 0, 0, 5'd9, 0, 1)));
        tbl.push_back(cy(ADD_7_5_2, LW_5, 1, 0, mk(1, 1, 0, 0, 0, 0, 5'd9, 0, 1)));
        tbl.push_back(cy(ADD_7_5_2, LW_5, 0, 0, mk(1, 0, 1, 0, 0, 1, 5'd9, 0, 1)));
        tbl.push_back(cy(ADD_7_5_2, 32'd0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd9, 0, 0)));
        foreach (tbl[i]) begin
            drive_cycle(tbl[i]);
            @(negedge clock);
            ex = sb.pop_front(); vectors++;
            if (got_m !== ex) begin
                miscompares++;
                $display("FAIL priority[%0d]: got %b expected %b", i, got_m, ex);
            end
        end
`ifdef HAZARD_STALL_STATS_EN
        vectors++;
        if (m_stall_cycles !== 16'd8) begin
            miscompares++;
            $display("FAIL stall_cycles: got %0d expected 8", m_stall_cycles);
        end
        vectors++;
        if (m_md_ops !== 16'd1) begin
            miscompares++;
            $display("FAIL md_ops: got %0d expected 1", m_md_ops);
        end
`endif
    endtask

    task automatic test_reset_mid_busy();
        cyc_t tbl[$];
        logic [12:0] ex;
        do_reset();
        tbl.push_back(cy(ADD_1_2_3, MUL_9, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0)));
        tbl.push_back(cy(ADD_1_2_3, MUL_9, 0, 0, mk(1, 1, 0, 1, 0, 0, 5'd9, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, MUL_9, 0, 0, mk(1, 1, 0, 0, 0, 0, 5'd9, 0, 1)));
        tbl.push_back(cy(ADD_1_2_3, MUL_9, 0, 0, mk(1, 1, 0, 0, 0, 0, 5'd9, 0, 1)));
        foreach (tbl[i]) begin
            drive_cycle(tbl[i]);
            @(negedge clock);
            ex = sb.pop_front(); vectors++;
            if (got_m !== ex) begin
                miscompares++;
                $display("FAIL mid_busy[%0d]: got %b expected %b", i, got_m, ex);
            end
        end
        #2;
        reset = 1'b0;
        dx_ir = '0;
        sb.push_back(13'd0);
        #1;
        ex = sb.pop_front(); vectors++;
        if (got_m !== ex) begin
            miscompares++;
            $display("FAIL async_reset: got %b expected %b", got_m, ex);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        tbl.delete();
        tbl.push_back(cy(ADD_1_2_3, 32'd0, 1, 0, mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0)));
        tbl.push_back(cy(ADD_1_2_3, 32'd0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0)));
        tbl.push_back(cy(ADD_1_2_3, 32'd0, 0, 0, mk(0, 0, 0, 0, 0, 0, 5'd0, 0, 0)));
        foreach (tbl[i]) begin
            drive_cycle(tbl[i]);
            @(negedge clock);
            ex = sb.pop_front(); vectors++;
            if (got_m !== ex) begin
                miscompares++;
                $display("FAIL late_rdy[%0d]: got %b expected %b", i, got_m, ex);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_multiply();
        test_div_exception();
        test_back_to_back();
        test_timeout();
        test_priority();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
